pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 107, payload width in bits (XM bundle: op 5, rd 5, regB 32, alu 32, tgt 32, of 1).
REQ-002 Parameter RESET_VAL, default 0, payload value loaded into all storage on reset.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled on rising edge of clock.
REQ-005 flush  input  1  drop all held entries (branch mispredict / exception kill).
REQ-006 in_valid  input  1  upstream offers in_data.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_data  output  DATA_W  oldest held payload.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 occupancy  output  2  number of held entries (0..2).

Function
REQ-013 Input transfer occurs iff in_valid && in_ready at a rising edge; output transfer iff out_valid && out_ready.
REQ-014 Entries leave in arrival order; no entry is duplicated or lost except by flush or reset.
REQ-015 out_valid and out_data come directly from registers, with no combinational path from in_* to out_*.
REQ-016 While out_valid && !out_ready, out_data and out_valid hold stable.
REQ-017 Latency: an entry accepted at edge N with the stage empty is presented on out_data after edge N (1 cycle).
REQ-018 Skid mode states: EMPTY (occ 0), ONE (occ 1, main slot), TWO (occ 2, main + skid slot).
REQ-019 EMPTY: input transfer -> ONE, main <= in_data.
REQ-020 ONE: in only -> TWO, skid <= in_data; in+out -> ONE, main <= in_data; out only -> EMPTY; neither -> ONE.
REQ-021 TWO: out -> ONE, main <= skid; no out -> TWO.
REQ-022 Skid mode: in_ready = (state != TWO) && !flush, decoded from registered state only; it does not depend on out_ready.
REQ-023 flush=1 at an edge: next state EMPTY, out_valid 0, occupancy 0; in_data offered that cycle is not accepted; flush wins over all simultaneous transfers.
REQ-024 Flush clears valid state only; slot payload registers retain their contents.
REQ-025 occupancy equals the state encoding at all times; out_valid = (occupancy != 0).

Reset
REQ-026 reset=0 at an edge: state EMPTY, out_valid 0, occupancy 0, both slots = RESET_VAL, out_data = RESET_VAL.
REQ-027 Reset overrides flush and any transfer in the same cycle; in_ready is 0 while reset=0.
REQ-028 The first cycle after reset deasserts: in_ready 1 (unless flush).

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: 2-entry skid behaviour per REQ-018..REQ-022, with full throughput and registered in_ready.
REQ-030 PIPE_STAGE_SKID_EN undefined: single slot only (states EMPTY/ONE, occupancy max 1); in_ready = (!out_valid || out_ready) && !flush (combinational from out_ready); in+out in ONE -> ONE with main <= in_data.
REQ-031 All other requirements hold in both builds.

Structure
REQ-032 Shared package pipe_pkg holds: state encoding constants (EMPTY=0, ONE=1, TWO=2), XM field widths/offsets (OP_LSB 0, RD_LSB 5, REGB_LSB 10, ALU_LSB 42, TGT_LSB 74, OF_BIT 106), and XM_W=107.
REQ-033 One sub-module pipe_slot: DATA_W-wide register with load enable and synchronous active-low reset to RESET_VAL; instantiated for main and skid slots.

Verification
REQ-034 Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=0x5A -> out_valid 0, occupancy 0, out_data 0, in_ready 0; after release, in_ready=1.
REQ-035 Streaming: out_ready=1, send A=1..8 back-to-back -> out_data 1..8 on consecutive cycles, 1-cycle latency, no bubbles (both builds).
REQ-036 Backpressure (skid build): out_ready=0, send 0xA,0xB,0xC -> accepts 0xA,0xB, occupancy 2, in_ready 0 while 0xC waits; raise out_ready -> 0xA,0xB,0xC emerge in order.
REQ-037 Flush: occupancy 2 holding 0x11,0x22; assert flush with in_valid=1, in_data=0x33 -> next cycle occupancy 0, out_valid 0; 0x33 never appears at the output.
REQ-038 Simultaneous events: in state ONE, in_valid and out_ready high together with new data 0x44 -> occupancy stays 1, out_data becomes 0x44 next cycle.
REQ-039 Non-skid build: out_ready=0 with occupancy 1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage codebase slice.
//
// Holds the state encoding used by pipe_stage (which is also the
// occupancy value presented on the occupancy port) and the field
// layout of the execute-to-memory (XM) payload bundle.
// The XM bundle is {of, tgt, alu, regB, rd, op}, with op in the LSBs.

package pipe_pkg;

    // State value doubles as the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // XM bundle field widths
    localparam int OP_W   = 5;
    localparam int RD_W   = 5;
    localparam int REGB_W = 32;
    localparam int ALU_W  = 32;
    localparam int TGT_W  = 32;
    localparam int OF_W   = 1;

    // XM bundle field offsets
    localparam int OP_LSB   = 0;
    localparam int RD_LSB   = 5;
    localparam int REGB_LSB = 10;
    localparam int ALU_LSB  = 42;
    localparam int TGT_LSB  = 74;
    localparam int OF_BIT   = 106;

    localparam int XM_W = 107;

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the pipeline stage.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-low; loads RESET_VAL
//   load   - capture d on the next rising edge
//   d      - DATA_W-bit payload in
//   q      - DATA_W-bit registered payload out

module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = XM_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register stage carrying the XM payload bundle.
//
// Build option (macro PIPE_STAGE_SKID_EN):
//   defined   - two-entry skid buffer (main + skid slot), full throughput,
//               in_ready decoded from registered state only.
//   undefined - single slot; in_ready is combinational from out_ready so
//               a held entry can be replaced in the cycle it leaves.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous, active-low
//   flush      - drop all held entries; payload registers keep contents
//   in_valid   - upstream offers in_data
//   in_data    - upstream payload (DATA_W bits)
//   in_ready   - stage accepts in_data this cycle
//   out_valid  - out_data holds a live entry
//   out_data   - oldest held payload, straight from the main slot register
//   out_ready  - downstream consumes out_data this cycle
//   occupancy  - number of held entries (0..2)

module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = XM_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    state_t            state;
    state_t            state_next;
    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
`ifdef PIPE_STAGE_SKID_EN
    logic              skid_load;
    logic [DATA_W-1:0] skid_q;
`endif

    assign occupancy = state;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

    // in_ready is held low during reset so nothing is reported as accepted
    // while the state register is being cleared.
`ifdef PIPE_STAGE_SKID_EN
    assign in_ready = (state != TWO) && !flush && reset;
`else
    assign in_ready = (!out_valid || out_ready) && !flush && reset;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register; reset dominates flush and every transfer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and slot load strobes. The main slot always holds the
    // oldest entry, so a departure from TWO promotes the skid entry.
    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        main_d     = in_data;
`ifdef PIPE_STAGE_SKID_EN
        skid_load  = 1'b0;
`endif
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_load  = 1'b1;
                    end
                end
                ONE: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_next = TWO;
                        skid_load  = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
`else
                    // Without a skid slot in_fire here implies out_fire.
                    if (in_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
`endif
                end
                TWO: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (out_fire) begin
                        state_next = ONE;
                        main_load  = 1'b1;
                        main_d     = skid_q;
                    end
`else
                    state_next = EMPTY;
`endif
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    pipe_slot #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_main_slot (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid_slot (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Directed, table-driven testbench for pipe_stage.
// Each table record is applied for one clock cycle: in_ready is checked
// before the rising edge, the registered outputs one time unit after it.
// Expected values differ between builds where the skid slot matters.

module tb_pipe_stage;

    localparam int W = 107;

    logic         clock;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   occupancy;

    int vectors_applied;
    int miscompares;

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         fl;
        logic         exp_ir;
        logic         exp_ov;
        logic [W-1:0] exp_od;
        logic [1:0]   exp_occ;
        string        name;
    } vec_t;

    vec_t vecs[$];

    pipe_stage #(
        .DATA_W    (W),
        .RESET_VAL ('0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void add(input logic rst, input logic iv,
                                input logic [W-1:0] id, input logic ordy,
                                input logic fl, input logic exp_ir,
                                input logic exp_ov, input logic [W-1:0] exp_od,
                                input logic [1:0] exp_occ, input string name);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_od = exp_od;
        v.exp_occ = exp_occ; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset     = v.rst;
        in_valid  = v.iv;
        in_data   = v.id;
        out_ready = v.ordy;
        flush     = v.fl;
        vectors_applied++;
        #1;
        check_output({v.name, " in_ready"}, W'(in_ready), W'(v.exp_ir));
        @(posedge clock);
        #1;
        check_output({v.name, " out_valid"}, W'(out_valid), W'(v.exp_ov));
        check_output({v.name, " out_data"}, out_data, v.exp_od);
        check_output({v.name, " occupancy"}, W'(occupancy), W'(v.exp_occ));
    endtask

    logic [W-1:0] all_ones;
    logic         skid;

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        all_ones        = '1;
`ifdef PIPE_STAGE_SKID_EN
        skid = 1'b1;
`else
        skid = 1'b0;
`endif
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //  rst iv  data      ordy fl  ir  ov  out_data  occ
        // Reset held two cycles with a live offer
        add(0, 1, 'h5A, 0, 0, 0, 0, 'h0, 0, "reset0");
        add(0, 1, 'h5A, 0, 0, 0, 0, 'h0, 0, "reset1");
        add(1, 0, 'h0,  1, 0, 1, 0, 'h0, 0, "post_reset");

        // Back-to-back stream 1..8 with one-cycle latency
        for (int k = 1; k <= 8; k++) begin
            add(1, 1, W'(k), 1, 0, 1, 1, W'(k), 1, $sformatf("stream%0d", k));
        end
        add(1, 0, 'h0, 1, 0, 1, 0, 'h8, 0, "stream_drain");

        // Full-width payload, then replace-while-leaving in state ONE
        add(1, 1, all_ones, 0, 0, 1, 1, all_ones, 1, "wide_load");
        add(1, 1, 'h44,     1, 0, 1, 1, 'h44,     1, "simul_in_out");
        add(1, 0, 'h0,      1, 0, 1, 0, 'h44,     0, "simul_drain");

        if (skid) begin
            // Backpressure fills both slots, C waits, then drains in order
            add(1, 1, 'hA, 0, 0, 1, 1, 'hA, 1, "bp_a");
            add(1, 1, 'hB, 0, 0, 1, 1, 'hA, 2, "bp_b");
            add(1, 1, 'hC, 0, 0, 0, 1, 'hA, 2, "bp_c_wait");
            add(1, 1, 'hC, 1, 0, 0, 1, 'hB, 1, "bp_out_a");
            add(1, 1, 'hC, 1, 0, 1, 1, 'hC, 1, "bp_c_in");
            add(1, 0, 'h0, 1, 0, 1, 0, 'hC, 0, "bp_drain");
            // Flush while full with a competing offer
            add(1, 1, 'h11, 0, 0, 1, 1, 'h11, 1, "fl_load11");
            add(1, 1, 'h22, 0, 0, 1, 1, 'h11, 2, "fl_load22");
            add(1, 1, 'h33, 1, 1, 0, 0, 'h11, 0, "flush_full");
        end else begin
            // Single slot: stalls until downstream takes the entry
            add(1, 1, 'hA, 0, 0, 1, 1, 'hA, 1, "bp_a");
            add(1, 1, 'hB, 0, 0, 0, 1, 'hA, 1, "bp_b_wait");
            add(1, 1, 'hB, 1, 0, 1, 1, 'hB, 1, "bp_b_in");
            add(1, 0, 'h0, 1, 0, 1, 0, 'hB, 0, "bp_drain");
            // Flush while holding one entry with a competing offer
            add(1, 1, 'h11, 0, 0, 1, 1, 'h11, 1, "fl_load11");
            add(1, 1, 'h33, 1, 1, 0, 0, 'h11, 0, "flush_one");
        end
        add(1, 0, 'h0, 1, 0, 1, 0, 'h11, 0, "post_flush");

        // Reset wins over flush and transfers; slots return to zero
        add(1, 1, 'h77, 0, 0, 1, 1, 'h77, 1, "pre_reset_load");
        add(0, 1, 'h78, 1, 1, 0, 0, 'h0,  0, "reset_override");
        add(1, 0, 'h0,  0, 0, 1, 0, 'h0,  0, "reset_release");

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // in_ready reaction to out_ready within one cycle while holding 0x60
        apply_stimulus('{1, 1, W'('h60), 0, 0, 1, 1, W'('h60), 2'd1, "comb_load"});
        in_valid  = 1'b1;
        in_data   = W'('h61);
        out_ready = 1'b0;
        vectors_applied++;
        #1;
        check_output("comb_ready_low", W'(in_ready), W'(skid));
        out_ready = 1'b1;
        #1;
        check_output("comb_ready_high", W'(in_ready), W'(1'b1));
        @(posedge clock);
        #1;
        check_output("comb_swap out_data", out_data, W'('h61));
        check_output("comb_swap occupancy", W'(occupancy), W'(2'd1));
        apply_stimulus('{1, 0, W'(0), 1, 0, 1, 0, W'('h61), 2'd0, "comb_drain"});

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
